// File: rtl/core_host_driver.sv
// core_host_driver: frames upstream payload words into a streaming FFT/FIR core
// and hands the core's result words downstream, one acknowledged word at a time.
module core_host_driver #(
    parameter int N_FFT_IN  = 64,
    parameter int N_FFT_OUT = 128,
    parameter int N_FIR_IN  = 16,
    parameter int N_FIR_OUT = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] core_data_in,
    output logic        core_data_in_valid,
    input  logic [15:0] core_data_out,
    input  logic        core_data_out_valid,
    output logic        core_tx_done,
    input  logic        core_busy,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, HDR, SEND, WAIT, HOLD, ACK, DONE, ERR} state_t;

    localparam logic [7:0]  FFT_IN     = 8'(N_FFT_IN);
    localparam logic [7:0]  FFT_OUT    = 8'(N_FFT_OUT);
    localparam logic [7:0]  FIR_IN     = 8'(N_FIR_IN);
    localparam logic [7:0]  FIR_OUT    = 8'(N_FIR_OUT);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [7:0]  n_in_q;
    logic [7:0]  n_out_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [15:0] timer_q;
    logic [15:0] res_data_q;
    logic [15:0] core_data_in_q;
    logic        res_valid_q;
    logic        core_data_in_valid_q;
    logic        tx_done_q;
    logic        done_q;
    logic        err_q;

    assign cnt_d              = cnt_q + 8'd1;
    assign src_ready          = (state_q == SEND);
    assign busy               = (state_q != IDLE);
    assign res_data           = res_data_q;
    assign res_valid          = res_valid_q;
    assign core_data_in       = core_data_in_q;
    assign core_data_in_valid = core_data_in_valid_q;
    assign core_tx_done       = tx_done_q;
    assign done               = done_q;
    assign err                = err_q;

    // Frame sequencer; every output is a flop so the core's falling-edge sampling sees stable values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q              <= IDLE;
            mode_q               <= 2'b00;
            n_in_q               <= 8'd0;
            n_out_q              <= 8'd0;
            cnt_q                <= 8'd0;
            timer_q              <= 16'd0;
            res_data_q           <= 16'd0;
            core_data_in_q       <= 16'd0;
            res_valid_q          <= 1'b0;
            core_data_in_valid_q <= 1'b0;
            tx_done_q            <= 1'b0;
            done_q               <= 1'b0;
            err_q                <= 1'b0;
        end else begin
            core_data_in_valid_q <= 1'b0;
            tx_done_q            <= 1'b0;
            done_q               <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && mode[1]) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else if (start && !core_busy) begin
                        mode_q  <= mode;
                        n_in_q  <= mode[0] ? FIR_IN : FFT_IN;
                        n_out_q <= mode[0] ? FIR_OUT : FFT_OUT;
                        cnt_q   <= 8'd0;
                        err_q   <= 1'b0;
                        state_q <= HDR;
                    end
                end
                // The header is registered here so it lands just ahead of the first payload word.
                HDR: begin
                    core_data_in_q       <= {14'b0, mode_q};
                    core_data_in_valid_q <= 1'b1;
                    state_q              <= SEND;
                end
                SEND: begin
                    if (src_valid) begin
                        core_data_in_q       <= src_data;
                        core_data_in_valid_q <= 1'b1;
                        if (cnt_d == n_in_q) begin
                            cnt_q   <= 8'd0;
                            timer_q <= 16'd0;
                            state_q <= WAIT;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                // A result word arriving on the last allowed cycle beats the timeout.
                WAIT: begin
                    if (core_data_out_valid) begin
                        res_data_q  <= core_data_out;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (timer_q == TIMER_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        tx_done_q   <= 1'b1;
                        state_q     <= ACK;
                    end
                end
                ACK: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == n_out_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        timer_q <= 16'd0;
                        state_q <= WAIT;
                    end
                end
                DONE: state_q <= IDLE;
                ERR: begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_host_driver.sv
// tb_core_host_driver: randomized frames against a queue scoreboard and a behavioural core model.
module tb_core_host_driver;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] src_data = 16'd0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] core_data_in;
    logic        core_data_in_valid;
    logic [15:0] core_data_out = 16'd0;
    logic        core_data_out_valid = 1'b0;
    logic        core_tx_done;
    logic        core_busy = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    core_host_driver #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstb(rstb), .start(start), .mode(mode),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .core_data_in(core_data_in), .core_data_in_valid(core_data_in_valid),
        .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
        .core_tx_done(core_tx_done), .core_busy(core_busy),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_ci[$];
    logic [15:0] exp_res[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected words whenever the DUT presents them.
    logic        ack_due = 1'b0;
    logic        hold_prev = 1'b0;
    logic [15:0] data_prev = 16'd0;
    int          run_cur = 0;
    int          last_run = 0;
    always @(negedge clk) begin
        if (core_data_in_valid) begin
            run_cur++;
            if (exp_ci.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL core_in_extra: got 0x%0h, want no word at %0t", core_data_in, $time);
            end else begin
                chk("core_in", core_data_in, exp_ci.pop_front());
            end
        end else begin
            if (run_cur > 0) last_run = run_cur;
            run_cur = 0;
        end
        chk("core_tx_done", core_tx_done, ack_due);
        if (hold_prev) begin
            chk("res_hold_valid", res_valid, 1);
            chk("res_hold_data", res_data, data_prev);
        end
        if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL res_extra: got 0x%0h, want no word at %0t", res_data, $time);
            end else begin
                chk("res_data", res_data, exp_res.pop_front());
            end
        end
        ack_due   = res_valid && res_ready;
        hold_prev = res_valid && !res_ready;
        data_prev = res_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [1:0] m, input int gap, input int hold_max,
                             input int bnd, input int hold_fix, input bit timeout);
        int ni, no, acc, t, d, h;
        logic [15:0] w;
        ni = m[0] ? 16 : 64;
        no = m[0] ? 16 : 128;
        exp_ci.push_back({14'b0, m});
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", busy, 1);
        chk("err_cleared", err, 0);
        acc = 0;
        t = 0;
        while (acc < ni && t < 2000) begin
            w = 16'($urandom);
            src_data = w;
            src_valid = ($urandom_range(99) >= gap);
            start = 1'($urandom_range(1));
            mode = 2'($urandom_range(3));
            core_data_out_valid = 1'($urandom_range(1));
            core_data_out = 16'($urandom);
            if (src_valid && src_ready) begin
                exp_ci.push_back(w);
                acc++;
            end
            tick();
            t++;
        end
        src_valid = 1'b0;
        start = 1'b0;
        core_data_out_valid = 1'b0;
        chk("payload_count", acc, ni);
        if (timeout) begin
            repeat (TO - 1) tick();
            chk("err_before_timeout", err, 0);
            chk("busy_waiting", busy, 1);
            repeat (2) tick();
            chk("err_timeout", err, 1);
            chk("busy_after_timeout", busy, 0);
            chk("core_in_drained", exp_ci.size(), 0);
            return;
        end
        for (int r = 0; r < no; r++) begin
            d = (r == bnd) ? TO : $urandom_range(6, (r == 0) ? 0 : 1);
            repeat (d) begin
                tick();
                core_data_out_valid = 1'b0;
            end
            w = 16'($urandom);
            core_data_out = w;
            core_data_out_valid = 1'b1;
            exp_res.push_back(w);
            tick();
            chk("res_valid", res_valid, 1);
            h = (r == 0 && hold_fix >= 0) ? hold_fix : $urandom_range(hold_max);
            res_ready = 1'b0;
            repeat (h) begin
                core_data_out_valid = 1'($urandom_range(1));
                core_data_out = 16'($urandom);
                start = 1'($urandom_range(1));
                mode = 2'($urandom_range(3));
                tick();
            end
            core_data_out_valid = 1'b0;
            start = 1'b0;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("tx_done_pulse", core_tx_done, 1);
            core_data_out_valid = 1'($urandom_range(1));
            core_data_out = 16'($urandom);
        end
        chk("done_early", done, 0);
        tick();
        core_data_out_valid = 1'b0;
        chk("done", done, 1);
        chk("busy_in_done", busy, 1);
        tick();
        chk("done_once", done, 0);
        chk("busy_idle", busy, 0);
        chk("err_clean", err, 0);
        chk("core_in_drained", exp_ci.size(), 0);
        chk("res_drained", exp_res.size(), 0);
        if (gap == 0) chk("burst_len", last_run, ni + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_core_in_valid"}, core_data_in_valid, 0);
        chk({tag, "_core_in"}, core_data_in, 0);
        chk({tag, "_tx_done"}, core_tx_done, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_all_zero("reset");
        rstb = 1'b1;
        tick();
        run_frame(2'b01, 0, 0, -1, -1, 1'b0);
        run_frame(2'b00, 50, 3, 3, -1, 1'b0);
        run_frame(2'b01, 30, 2, -1, 10, 1'b0);
        run_frame(2'b01, 0, 0, -1, -1, 1'b1);
        repeat (5) tick();
        chk("err_sticky", err, 1);
        run_frame(2'b01, 20, 1, 2, -1, 1'b0);
        mode = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("badmode_err", err, 1);
        tick();
        chk("badmode_idle", busy, 0);
        mode = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("badmode11_err", err, 1);
        chk("badmode11_idle", busy, 0);
        core_busy = 1'b1;
        mode = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        core_busy = 1'b0;
        chk("corebusy_ignored", busy, 0);
        chk("corebusy_err_kept", err, 1);
        run_frame(2'b00, 10, 2, -1, -1, 1'b0);
        exp_ci.push_back(16'h0001);
        mode = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src_data = 16'(i + 16'h100);
            src_valid = 1'b1;
            if (src_ready) exp_ci.push_back(src_data);
            tick();
        end
        chk("send_before_reset", src_ready, 1);
        #2;
        rstb = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_ci.delete();
        repeat (3) tick();
        rstb = 1'b1;
        repeat (10) tick();
        chk("after_reset_idle", busy, 0);
        chk("after_reset_ready", src_ready, 0);
        src_valid = 1'b0;
        run_frame(2'b01, 40, 2, 5, -1, 1'b0);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/core_host_driver.md
CORE_HOST_DRIVER -- requirements
Module: core_host_driver

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- N_FFT_IN, 64, FFT payload words sent
- N_FFT_OUT, 128, FFT result words received
- N_FIR_IN, 16, FIR payload words sent
- N_FIR_OUT, 16, FIR result words received
- TIMEOUT, 4096, maximum idle cycles while waiting for a result word

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock; all state updates on the rising edge
- rstb, in, 1, reset; asynchronous, active-low
- start, in, 1, request one frame transaction
- mode, in, 2, 00 = FFT, 01 = FIR; sampled with start
- src_data, in, 16, payload word from upstream
- src_valid, in, 1, src_data is valid
- src_ready, out, 1, driver accepts src_data this cycle
- res_data, out, 16, result word to downstream
- res_valid, out, 1, res_data is valid
- res_ready, in, 1, downstream accepts res_data
- core_data_in, out, 16, word to core receive channel
- core_data_in_valid, out, 1, core_data_in is valid
- core_data_out, in, 16, word from core transmit channel
- core_data_out_valid, in, 1, core_data_out is valid
- core_tx_done, out, 1, acknowledge of one core result word
- core_busy, in, 1, core is computing or transmitting
- busy, out, 1, driver not in IDLE
- done, out, 1, one-cycle pulse on frame completion
- err, out, 1, sticky error flag

Function
REQ-003 The FSM SHALL have the states IDLE, HDR, SEND, WAIT, HOLD, ACK, DONE and ERR.
REQ-004 In IDLE, start=1 with core_busy=0 and mode[1]=0 SHALL latch the mode, select n_in/n_out from mode, clear the word counter, clear err and go to HDR.
REQ-005 In IDLE, start=1 with mode[1]=1 SHALL go to ERR; start=1 with core_busy=1 SHALL be ignored.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 HDR SHALL drive core_data_in={14'b0, mode} with core_data_in_valid=1 for exactly one cycle, then go to SEND.
REQ-008 src_ready SHALL equal (state==SEND); each cycle with src_valid and src_ready high SHALL register src_data onto core_data_in with core_data_in_valid=1 on the next cycle.
REQ-009 core_data_in_valid SHALL be 0 in any cycle without a transfer, which allows gaps; header and payload words SHALL be back-to-back when src_valid is held high.
REQ-010 The n_in-th accepted payload word SHALL move the FSM to WAIT; no further src_ready is asserted.
REQ-011 All core-side outputs SHALL change only on rising edges, so the core's falling-edge sampling sees stable values.
REQ-012 In WAIT, core_data_out_valid=1 SHALL capture core_data_out into res_data, set res_valid=1, and go to HOLD.
REQ-013 In WAIT, a 16-bit timer SHALL count cycles; reaching TIMEOUT with no core_data_out_valid SHALL go to ERR.
REQ-014 The timer SHALL clear on entry to WAIT.
REQ-015 HOLD SHALL keep res_valid and res_data stable until res_ready=1; on that handshake, res_valid SHALL drop on the next cycle and the FSM SHALL go to ACK.
REQ-016 ACK SHALL assert core_tx_done for exactly one cycle and increment the result counter.
REQ-017 From ACK, the FSM SHALL go to DONE if the counter reaches n_out, else to WAIT.
REQ-018 core_data_out_valid pulses arriving outside WAIT SHALL be ignored; a pulse coinciding with the timeout cycle SHALL take priority over the timeout.
REQ-019 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-020 ERR SHALL set err=1, then go to IDLE; err SHALL stay high until the next accepted start or reset.
REQ-021 busy SHALL equal (state!=IDLE).
REQ-022 Counters SHALL be 8 bits wide; n_out=128 SHALL be represented without wrap.

Reset
REQ-023 rstb=0 SHALL asynchronously force state=IDLE and clear the counters and timer.
REQ-024 rstb=0 SHALL force src_ready, res_valid, core_data_in_valid, core_tx_done, done, err and busy to 0, and res_data and core_data_in to 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no further core-side activity; a new start is needed after reset.

Verification
REQ-026 Scenario: FIR start, mode=01, src words 1..16 back-to-back -> header 0x0001 then 16 consecutive valid words, then WAIT.
REQ-027 Scenario: core returns 16 words, each acked with a one-cycle core_tx_done, res_ready=1 -> 16 res_valid words in order, then done pulse, busy=0.
REQ-028 Scenario: FFT, mode=00, 64 words with src_valid toggling -> exactly 64 payload words, gaps where src_valid=0; 128 results received, then done.
REQ-029 Scenario: res_ready held 0 for 10 cycles during HOLD -> res_data stable, no core_tx_done until res_ready=1.
REQ-030 Scenario: no core_data_out_valid for TIMEOUT cycles -> err=1, return to IDLE; the next start clears err.
REQ-031 Scenario: start with mode=10, and separately start with core_busy=1 -> err=1 and IDLE in the first case, no state change in the second; rstb pulsed during SEND -> all outputs 0 immediately.
